// File: rtl/d_write_buffer.sv
// Posted write buffer between the data cache and memory: a small FIFO of
// stores drained one beat at a time. Define WB_FORWARD_EN for load forwarding.
module d_write_buffer #(
    parameter int A_WIDTH   = 32,
    parameter int DEPTH_LOG = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] c_a,
    input  logic [31:0]        c_din,
    output logic [31:0]        c_dout,
    input  logic               c_strobe,
    input  logic               c_rw,
    output logic               c_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    input  logic [31:0]        m_dout,
    output logic               m_strobe,
    output logic               m_rw,
    input  logic               m_ready,
    output logic               wb_empty,
    output logic               wb_full
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;
    state_t state, state_next;

    logic [A_WIDTH-1:0]   addr_q [DEPTH];
    logic [31:0]          data_q [DEPTH];
    logic [DEPTH_LOG-1:0] head, tail;
    logic [DEPTH_LOG:0]   count;
    logic [A_WIDTH-1:0]   rd_addr;

    logic        full, empty;
    logic        push, pop, rd_start;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign wb_empty = rst | empty;
    assign wb_full  = ~rst & full;

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((DEPTH_LOG + 1)'(i) < count) &&
                (addr_q[head + DEPTH_LOG'(i)][A_WIDTH-1:2] == c_a[A_WIDTH-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head + DEPTH_LOG'(i)];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        state_next = state;
        m_strobe   = 1'b0;
        m_rw       = 1'b0;
        m_a        = '0;
        m_din      = '0;
        c_ready    = 1'b0;
        c_dout     = '0;
        push       = 1'b0;
        pop        = 1'b0;
        rd_start   = 1'b0;
        if (!rst) begin
            // Full is judged on the registered count, so a same-cycle pop does not free a slot.
            if (c_strobe && c_rw && !full) begin
                c_ready = 1'b1;
                push    = 1'b1;
            end
            if (c_strobe && !c_rw && fwd_hit) begin
                c_ready = 1'b1;
                c_dout  = fwd_data;
            end
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state_next = ST_WRITE;
                    end else if (c_strobe && !c_rw && !fwd_hit) begin
                        state_next = ST_READ;
                        rd_start   = 1'b1;
                    end
                end
                ST_WRITE: begin
                    m_strobe = 1'b1;
                    m_rw     = 1'b1;
                    m_a      = addr_q[head];
                    m_din    = data_q[head];
                    if (m_ready) begin
                        pop        = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_READ: begin
                    m_strobe = 1'b1;
                    m_a      = rd_addr;
                    if (m_ready) begin
                        state_next = ST_IDLE;
                        if (c_strobe && !c_rw) begin
                            c_ready = 1'b1;
                            c_dout  = m_dout;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_addr <= '0;
        end else begin
            state <= state_next;
            if (rd_start) rd_addr <= c_a;
            if (push) tail <= tail + DEPTH_LOG'(1);
            if (pop)  head <= head + DEPTH_LOG'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= c_a;
            data_q[tail] <= c_din;
        end
    end

endmodule
